// File: rtl/wb_trace_unit_pkg.sv
// Shared constants and serialiser state encoding for the write-back trace unit.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a 32-bit timestamp to every record).
package wb_trace_unit_pkg;

    localparam logic [7:0] TRACE_HDR_BYTE = 8'hA5;
    localparam logic [7:0] TRACE_END_BYTE = 8'h5A;
    localparam logic [1:0] WORD_LAST      = 2'd3;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W        = 32;
    localparam int FRAME_BYTES = 10;
`else
    localparam int TS_W        = 0;
    localparam int FRAME_BYTES = 6;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_REG       = 3'd2,
        ST_DATA      = 3'd3,
        ST_END_HDR   = 3'd4,
        ST_END_FLAGS = 3'd5,
        ST_DONE      = 3'd6
`ifdef TRACE_TIMESTAMP_EN
        , ST_TS      = 3'd7
`endif
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding captured write-back records; DEPTH must be a power of 2.
module trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_trace_unit.sv
// Captures committed register writes and streams them as byte frames to the debug UART.
// Optional feature macro: TRACE_TIMESTAMP_EN (timestamp appended after the data bytes).
module wb_trace_unit
    import wb_trace_unit_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wb_reg_write,
    input  logic [REG_W-1:0]        i_wb_write_register,
    input  logic [DATA_W-1:0]       i_wb_write_data,
    input  logic                    i_halt,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic [$clog2(DEPTH):0]  o_fifo_level,
    output logic                    o_overflow,
    output logic                    o_done
);

    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = REG_W + DATA_W + TS_W;
    // Everything after the header byte; the frame layout assumes DATA_W is 32.
    localparam int SREG_W  = 8 * (FRAME_BYTES - 1);

    trace_state_t        state, next_state;
    logic [SREG_W-1:0]   sreg, next_sreg;
    logic [1:0]          cnt, next_cnt;
    logic [7:0]          tx_data_q, next_tx_data;
    logic                tx_valid_q, next_tx_valid;
    logic                done_q, next_done;
    logic                halt_seen;
    logic                overflow_q;

    logic                push_req;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_wr;
    logic [ENTRY_W-1:0]  fifo_rd;
    logic [LEVEL_W-1:0]  fifo_level;
    logic                xfer;
    logic [7:0]          sreg_top;
    logic [SREG_W-1:0]   sreg_shifted;

    // Writes to r0 never change architectural state, so they are not traced.
    assign push_req     = i_wb_reg_write && (i_wb_write_register != '0) && !halt_seen;
    assign xfer         = tx_valid_q && i_tx_ready;
    assign sreg_top     = sreg[SREG_W-1 -: 8];
    assign sreg_shifted = sreg << 8;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_count <= '0;
        end else begin
            ts_count <= ts_count + 32'd1;
        end
    end

    assign fifo_wr = {i_wb_write_register, i_wb_write_data, ts_count};
`else
    assign fifo_wr = {i_wb_write_register, i_wb_write_data};
`endif

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The commit coinciding with the first i_halt is still captured because halt_seen lags a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_seen  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (i_halt) begin
                halt_seen <= 1'b1;
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= next_state;
            sreg       <= next_sreg;
            cnt        <= next_cnt;
            tx_data_q  <= next_tx_data;
            tx_valid_q <= next_tx_valid;
            done_q     <= next_done;
        end
    end

    // State names the byte currently presented; each accepted byte loads the next one.
    always_comb begin
        next_state    = state;
        next_sreg     = sreg;
        next_cnt      = cnt;
        next_tx_data  = tx_data_q;
        next_tx_valid = tx_valid_q;
        next_done     = done_q;
        fifo_pop      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    next_sreg     = {8'(fifo_rd[ENTRY_W-1 -: REG_W]), fifo_rd[ENTRY_W-REG_W-1:0]};
                    next_tx_data  = TRACE_HDR_BYTE;
                    next_tx_valid = 1'b1;
                    next_state    = ST_HDR;
                end else if (halt_seen) begin
                    next_tx_data  = TRACE_END_BYTE;
                    next_tx_valid = 1'b1;
                    next_state    = ST_END_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    next_tx_data = sreg_top;
                    next_sreg    = sreg_shifted;
                    next_state   = ST_REG;
                end
            end
            ST_REG: begin
                if (xfer) begin
                    next_tx_data = sreg_top;
                    next_sreg    = sreg_shifted;
                    next_cnt     = 2'd0;
                    next_state   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (cnt != WORD_LAST) begin
                        next_tx_data = sreg_top;
                        next_sreg    = sreg_shifted;
                        next_cnt     = cnt + 2'd1;
                    end else begin
`ifdef TRACE_TIMESTAMP_EN
                        next_tx_data  = sreg_top;
                        next_sreg     = sreg_shifted;
                        next_cnt      = 2'd0;
                        next_state    = ST_TS;
`else
                        next_tx_data  = 8'h00;
                        next_tx_valid = 1'b0;
                        next_state    = ST_IDLE;
`endif
                    end
                end
            end
`ifdef TRACE_TIMESTAMP_EN
            ST_TS: begin
                if (xfer) begin
                    if (cnt != WORD_LAST) begin
                        next_tx_data = sreg_top;
                        next_sreg    = sreg_shifted;
                        next_cnt     = cnt + 2'd1;
                    end else begin
                        next_tx_data  = 8'h00;
                        next_tx_valid = 1'b0;
                        next_state    = ST_IDLE;
                    end
                end
            end
`endif
            ST_END_HDR: begin
                if (xfer) begin
                    next_tx_data = {7'b0, overflow_q};
                    next_state   = ST_END_FLAGS;
                end
            end
            ST_END_FLAGS: begin
                if (xfer) begin
                    next_tx_data  = 8'h00;
                    next_tx_valid = 1'b0;
                    next_done     = 1'b1;
                    next_state    = ST_DONE;
                end
            end
            ST_DONE: begin
                next_tx_valid = 1'b0;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign o_tx_data    = tx_data_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_fifo_level = fifo_level;
    assign o_overflow   = overflow_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_wb_trace_unit.sv
// Directed testbench for wb_trace_unit in its default build (no timestamp).
module tb_wb_trace_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_wb_reg_write = 1'b0;
    logic [4:0]  i_wb_write_register = '0;
    logic [31:0] i_wb_write_data = '0;
    logic        i_halt = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic [4:0]  o_fifo_level;
    logic        o_overflow;
    logic        o_done;

    int checks = 0;
    int passed = 0;

    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];

    wb_trace_unit #(
        .DEPTH  (16),
        .DATA_W (32),
        .REG_W  (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_wb_reg_write      (i_wb_reg_write),
        .i_wb_write_register (i_wb_write_register),
        .i_wb_write_data     (i_wb_write_data),
        .i_halt              (i_halt),
        .o_tx_data           (o_tx_data),
        .o_tx_valid          (o_tx_valid),
        .i_tx_ready          (i_tx_ready),
        .o_fifo_level        (o_fifo_level),
        .o_overflow          (o_overflow),
        .o_done              (o_done)
    );

    always #5 clk = ~clk;

    // Bytes accepted by the transmitter; the transfer completes at the following rising edge.
    always @(negedge clk) begin
        if (!reset && o_tx_valid && i_tx_ready) begin
            byte_q.push_back(o_tx_data);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_wb_reg_write = 1'b0;
        i_wb_write_register = '0;
        i_wb_write_data = '0;
        i_halt = 1'b0;
        i_tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        byte_q.delete();
        exp_q.delete();
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] d);
        i_wb_reg_write = 1'b1;
        i_wb_write_register = r;
        i_wb_write_data = d;
        @(posedge clk);
        #1;
        i_wb_reg_write = 1'b0;
    endtask

    task automatic add_frame(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back({3'b000, r});
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (byte_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_tx_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", o_tx_valid);
        else passed++;
        checks++;
        if (o_tx_data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", o_tx_data);
        else passed++;
        checks++;
        if (o_fifo_level !== 5'd0) $display("[TB] FAIL reset_level: got %0d expected 0", o_fifo_level);
        else passed++;
        checks++;
        if (o_overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", o_overflow);
        else passed++;
        checks++;
        if (o_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", o_done);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        bit ok;
        apply_reset();
        add_frame(5'd8, 32'hDEADBEEF);
        commit(5'd8, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (o_fifo_level !== 5'd1 || o_tx_valid !== 1'b0)
            $display("[TB] FAIL single_latency1: got level=%0d valid=%b expected level=1 valid=0", o_fifo_level, o_tx_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA5)
            $display("[TB] FAIL single_latency2: got valid=%b data=%h expected valid=1 data=a5", o_tx_valid, o_tx_data);
        else passed++;
        @(posedge clk);
        #1;
        wait_bytes(6, 50, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || byte_q.size() != 6) $display("[TB] FAIL single_count: got %0d bytes expected 6", byte_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= byte_q.size()) $display("[TB] FAIL single_byte%0d: got none expected %h", i, exp_q[i]);
            else if (byte_q[i] !== exp_q[i]) $display("[TB] FAIL single_byte%0d: got %h expected %h", i, byte_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        apply_reset();
        i_tx_ready = 1'b0;
        add_frame(5'd8, 32'hCAFEF00D);
        commit(5'd8, 32'hCAFEF00D);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_tx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) $display("[TB] FAIL bp_first_valid: got valid=0 expected 1 within 20 cycles");
        else passed++;
        @(posedge clk);
        #1;
        i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        i_tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h08)
                $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h expected valid=1 data=08", c, o_tx_valid, o_tx_data);
            else passed++;
        end
        @(posedge clk);
        #1;
        i_tx_ready = 1'b1;
        wait_bytes(6, 50, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || byte_q.size() != 6) $display("[TB] FAIL bp_count: got %0d bytes expected 6", byte_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= byte_q.size()) $display("[TB] FAIL bp_byte%0d: got none expected %h", i, exp_q[i]);
            else if (byte_q[i] !== exp_q[i]) $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, byte_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_filtered();
        apply_reset();
        commit(5'd0, 32'h12345678);
        i_wb_reg_write = 1'b0;
        i_wb_write_register = 5'd5;
        i_wb_write_data = 32'h87654321;
        @(posedge clk);
        #1;
        repeat (6) @(negedge clk);
        checks++;
        if (o_fifo_level !== 5'd0) $display("[TB] FAIL filt_level: got %0d expected 0", o_fifo_level);
        else passed++;
        checks++;
        if (o_tx_valid !== 1'b0) $display("[TB] FAIL filt_valid: got %b expected 0", o_tx_valid);
        else passed++;
        checks++;
        if (byte_q.size() != 0) $display("[TB] FAIL filt_bytes: got %0d bytes expected 0", byte_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        apply_reset();
        commit(5'd9, 32'h11223344);
        wait_bytes(3, 50, ok);
        checks++;
        if (!ok) $display("[TB] FAIL rmid_progress: got %0d bytes expected 3", byte_q.size());
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 || o_fifo_level !== 5'd0)
            $display("[TB] FAIL rmid_cleared: got valid=%b data=%h level=%0d expected 0/00/0", o_tx_valid, o_tx_data, o_fifo_level);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        byte_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (o_tx_valid !== 1'b0) $display("[TB] FAIL rmid_no_resume: got valid=%b expected 0", o_tx_valid);
        else passed++;
        @(posedge clk);
        #1;
        add_frame(5'd10, 32'h55667788);
        commit(5'd10, 32'h55667788);
        wait_bytes(6, 50, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || byte_q.size() != 6) $display("[TB] FAIL rmid_count: got %0d bytes expected 6", byte_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= byte_q.size()) $display("[TB] FAIL rmid_byte%0d: got none expected %h", i, exp_q[i]);
            else if (byte_q[i] !== exp_q[i]) $display("[TB] FAIL rmid_byte%0d: got %h expected %h", i, byte_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    // The first record leaves the FIFO immediately into the stalled serialiser,
    // so 1 + 16 records survive out of 20 and commits 17..19 are dropped.
    task automatic test_overflow_halt();
        bit ok;
        apply_reset();
        i_tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_wb_reg_write = 1'b1;
            i_wb_write_register = 5'(i + 1);
            i_wb_write_data = 32'h0BAD0000 + 32'(i);
            if (i < 17) add_frame(5'(i + 1), 32'h0BAD0000 + 32'(i));
            @(posedge clk);
            #1;
        end
        i_wb_reg_write = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h01);
        @(negedge clk);
        checks++;
        if (o_fifo_level !== 5'd16) $display("[TB] FAIL ovf_level: got %0d expected 16", o_fifo_level);
        else passed++;
        checks++;
        if (o_overflow !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", o_overflow);
        else passed++;
        @(posedge clk);
        #1;
        i_halt = 1'b1;
        i_tx_ready = 1'b1;
        wait_bytes(104, 400, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || byte_q.size() != 104) $display("[TB] FAIL ovf_count: got %0d bytes expected 104", byte_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= byte_q.size()) $display("[TB] FAIL ovf_byte%0d: got none expected %h", i, exp_q[i]);
            else if (byte_q[i] !== exp_q[i]) $display("[TB] FAIL ovf_byte%0d: got %h expected %h", i, byte_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (o_done !== 1'b1 || o_tx_valid !== 1'b0)
            $display("[TB] FAIL ovf_done: got done=%b valid=%b expected done=1 valid=0", o_done, o_tx_valid);
        else passed++;
    endtask

    task automatic test_halt_drain();
        bit ok;
        apply_reset();
        add_frame(5'd1, 32'h000000A1);
        add_frame(5'd2, 32'h000000A2);
        add_frame(5'd3, 32'h000000A3);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        commit(5'd1, 32'h000000A1);
        commit(5'd2, 32'h000000A2);
        i_halt = 1'b1;
        commit(5'd3, 32'h000000A3);
        commit(5'd4, 32'h000000A4);
        commit(5'd5, 32'h000000A5);
        wait_bytes(20, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || byte_q.size() != 20) $display("[TB] FAIL halt_count: got %0d bytes expected 20", byte_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= byte_q.size()) $display("[TB] FAIL halt_byte%0d: got none expected %h", i, exp_q[i]);
            else if (byte_q[i] !== exp_q[i]) $display("[TB] FAIL halt_byte%0d: got %h expected %h", i, byte_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (o_done !== 1'b1 || o_tx_valid !== 1'b0 || o_fifo_level !== 5'd0)
            $display("[TB] FAIL halt_done: got done=%b valid=%b level=%0d expected 1/0/0", o_done, o_tx_valid, o_fifo_level);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_filtered();
        test_reset_mid_frame();
        test_overflow_halt();
        test_halt_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
